// File: rtl/sq_write_issue.sv
// Store-queue drain engine: pops released stores into a one-entry write request register,
// bounds in-flight writes with credits, and supports a drain handshake.
// Optional ack watchdog enabled by SQ_WRITE_ISSUE_ACK_TIMEOUT_EN.
module sq_write_issue #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SUBUNIT_W       = 2,
  parameter int unsigned ACK_TIMEOUT     = 1024,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sq_valid,
  input  logic [31:0]          sq_addr,
  input  logic [3:0]           sq_be,
  input  logic [31:0]          sq_data,
  input  logic [SUBUNIT_W-1:0] sq_subunit_id,
  output logic                 sq_pop,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [31:0]          wr_addr,
  output logic [3:0]           wr_be,
  output logic [31:0]          wr_data,
  output logic [SUBUNIT_W-1:0] wr_subunit_id,
  input  logic                 wr_ack,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic [CW-1:0]        credits,
  output logic                 ack_underflow,
  output logic                 ack_timeout
);

  typedef enum logic [1:0] {StRun, StDraining, StDrained} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           wr_valid_q, wr_valid_d;
  logic           underflow_q;
  logic           ack_ok;

  assign ack_ok = wr_ack && (credits_q != '0);

  // The buffered request already holds a credit, so the credit check alone bounds issue.
  assign sq_pop = sq_valid && (state_q == StRun) && (!wr_valid_q || wr_ready) &&
                  (credits_q < CW'(MAX_OUTSTANDING));

  assign wr_valid_d = sq_pop || (wr_valid_q && !wr_ready);
  assign credits_d  = credits_q + CW'(sq_pop) - CW'(ack_ok);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain_req) state_d = StDraining;
      end
      StDraining: begin
        if (!drain_req) begin
          state_d = StRun;
        end else if ((credits_d == '0) && !wr_valid_d) begin
          state_d = StDrained;
        end
      end
      StDrained: begin
        if (!drain_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      credits_q   <= '0;
      wr_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      wr_valid_q  <= wr_valid_d;
      if (wr_ack && (credits_q == '0)) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sq_pop) begin
      wr_addr       <= sq_addr;
      wr_be         <= sq_be;
      wr_data       <= sq_data;
      wr_subunit_id <= sq_subunit_id;
    end
  end

  assign wr_valid      = wr_valid_q;
  assign credits       = credits_q;
  assign ack_underflow = underflow_q;
  assign drain_done    = (state_q == StDrained);

`ifdef SQ_WRITE_ISSUE_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (wr_ack || (credits_q == '0)) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TW'(ACK_TIMEOUT)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (to_cnt_q == TW'(ACK_TIMEOUT)) to_flag_q <= 1'b1;
    end
  end

  assign ack_timeout = to_flag_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^ACK_TIMEOUT;
  assign ack_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_sq_write_issue.sv
// Bench for sq_write_issue: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of pops, credits and the drain handshake.
module tb_sq_write_issue;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst, sq_valid, sq_pop, wr_valid, wr_ready, wr_ack, drain_req, drain_done;
  logic [31:0] sq_addr, sq_data, wr_addr, wr_data;
  logic [3:0]  sq_be, wr_be;
  logic [1:0]  sq_subunit_id, wr_subunit_id;
  logic [2:0]  credits;
  logic        ack_underflow, ack_timeout;

  int errors = 0;
  int checks = 0;
  int pops_seen = 0;

  // Model: outstanding count, the single buffered request, and drain phase (0 run/1 draining/2 done).
  int          m_cred, m_mode;
  bit          m_wv, m_under;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_be;
  logic [1:0]  m_sub;

  always #5 clk = ~clk;

  sq_write_issue #(
    .MAX_OUTSTANDING(MAXO),
    .SUBUNIT_W      (2),
`ifdef SQ_WRITE_ISSUE_ACK_TIMEOUT_EN
    .ACK_TIMEOUT    (16)
`else
    .ACK_TIMEOUT    (1024)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sq_valid     (sq_valid),
    .sq_addr      (sq_addr),
    .sq_be        (sq_be),
    .sq_data      (sq_data),
    .sq_subunit_id(sq_subunit_id),
    .sq_pop       (sq_pop),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .wr_subunit_id(wr_subunit_id),
    .wr_ack       (wr_ack),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .credits      (credits),
    .ack_underflow(ack_underflow),
    .ack_timeout  (ack_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred = 0; m_mode = 0; m_wv = 0; m_under = 0;
  endtask

  // One clock: check outputs at negedge against the model, then advance model and clock.
  task automatic cycle();
    bit pop, nwv;
    int nc;
    @(negedge clk);
    pop = sq_valid && (m_mode == 0) && (!m_wv || wr_ready) && (m_cred < MAXO);
    chk("sq_pop", sq_pop, pop);
    chk("wr_valid", wr_valid, m_wv);
    if (m_wv) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_be", wr_be, m_be);
      chk("wr_data", wr_data, m_data);
      chk("wr_subunit_id", wr_subunit_id, m_sub);
    end
    chk("credits", credits, m_cred);
    chk("drain_done", drain_done, m_mode == 2);
    chk("ack_underflow", ack_underflow, m_under);
`ifndef SQ_WRITE_ISSUE_ACK_TIMEOUT_EN
    chk("ack_timeout", ack_timeout, 1'b0);
`endif
    if (sq_pop) pops_seen++;
    if (rst) begin
      model_reset();
    end else begin
      nc  = m_cred + int'(pop) - int'(wr_ack && m_cred != 0);
      nwv = pop || (m_wv && !wr_ready);
      if (wr_ack && m_cred == 0) m_under = 1;
      if (pop) begin
        m_addr = sq_addr; m_be = sq_be; m_data = sq_data; m_sub = sq_subunit_id;
      end
      if (m_mode == 0) begin
        if (drain_req) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!drain_req) m_mode = 0;
        else if (nc == 0 && !nwv) m_mode = 2;
      end else if (!drain_req) begin
        m_mode = 0;
      end
      m_cred = nc;
      m_wv   = nwv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    sq_valid = 1; sq_addr = a; sq_be = b; sq_data = d; sq_subunit_id = a[1:0];
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    rst = 1; sq_valid = 0; sq_addr = 0; sq_be = 0; sq_data = 0; sq_subunit_id = 0;
    wr_ready = 0; wr_ack = 0; drain_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset values
    cycle();

    // Single store: pop now, request next cycle
    set_store(32'h1000, 4'hF, 32'hDEADBEEF); wr_ready = 1;
    cycle();
    sq_valid = 0;
    cycle();
    chk("first_credit", credits, 3'd1);
    wr_ack = 1; cycle(); wr_ack = 0;

    // Backpressure with a second store pending
    set_store(32'h2004, 4'h3, 32'hA5A5_0001); cycle();
    wr_ready = 0; set_store(32'h3008, 4'hC, 32'h5A5A_0002);
    pops_seen = 0;
    repeat (5) cycle();
    chk("no_pop_stalled", pops_seen, 0);
    wr_ready = 1; cycle();
    chk("pop_on_accept", pops_seen, 1);
    sq_valid = 0; cycle();

    // Credit limit: six stores offered, four pops
    do_reset();
    pops_seen = 0;
    for (int i = 0; i < 6; i++) begin
      set_store(32'h4000 + 32'(i * 4), 4'hF, $urandom); cycle();
    end
    chk("limit_pops", pops_seen, 4);
    chk("limit_credits", credits, 3'd4);
    wr_ack = 1; cycle(); wr_ack = 0; cycle();
    chk("ack_frees_one", pops_seen, 5);
    chk("limit_credits2", credits, 3'd4);
    sq_valid = 0;

    // Drain with credits=3 and a request buffered
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_store(32'h5000 + 32'(i * 4), 4'h1, $urandom); cycle();
    end
    chk("drain_setup_credits", credits, 3'd3);
    wr_ready = 0; drain_req = 1;
    pops_seen = 0;
    repeat (2) cycle();
    wr_ready = 1; cycle(); wr_ready = 0;
    wr_ack = 1; repeat (2) cycle();
    chk("not_yet_drained", drain_done, 1'b0);
    cycle(); wr_ack = 0;
    chk("drain_done_after_ack", drain_done, 1'b1);
    chk("no_pop_draining", pops_seen, 0);
    repeat (2) cycle();
    drain_req = 0; cycle();
    wr_ready = 1; cycle();
    chk("pops_resume", pops_seen, 1);
    sq_valid = 0; cycle();

    // Ack with no credits: sticky underflow
    do_reset();
    wr_ack = 1; cycle(); wr_ack = 0;
    repeat (3) cycle();
    chk("underflow_sticky", ack_underflow, 1'b1);
    chk("underflow_credits", credits, 3'd0);
    do_reset();
    chk("underflow_cleared", ack_underflow, 1'b0);

    // Random traffic with legal acks
    for (int n = 0; n < 600; n++) begin
      sq_valid      = ($urandom_range(0, 9) < 7);
      sq_addr       = $urandom; sq_data = $urandom;
      sq_be         = 4'($urandom); sq_subunit_id = 2'($urandom);
      wr_ready      = ($urandom_range(0, 3) != 0);
      wr_ack        = (((m_cred - int'(m_wv)) > 0) || (m_wv && wr_ready)) &&
                      ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) drain_req = !drain_req;
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; sq_valid = 0; wr_ack = 0; drain_req = 0;

`ifdef SQ_WRITE_ISSUE_ACK_TIMEOUT_EN
    begin
      int waited;
      do_reset();
      set_store(32'h6000, 4'hF, 32'h1234_5678); wr_ready = 1; cycle();
      sq_valid = 0; cycle();
      waited = 0;
      while (!ack_timeout && waited < 40) begin
        @(posedge clk); #1; waited++;
      end
      chk("ack_timeout_set", ack_timeout, 1'b1);
      chk("ack_timeout_not_early", waited >= 14, 1'b1);
    end
`else
    chk("ack_timeout_off", ack_timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
